// File: rtl/spi_controller_tx.sv
// SPI mode-0 write controller. Takes one {addr, data} request per valid/ready
// handshake and shifts it out MSB first as a 16-bit write frame
// {1'b1, addr[6:0], data[7:0]} on ncs/sclk/copi. All serial outputs are
// registered, so they never glitch and reset forces them idle at once.
module spi_controller_tx #(
  parameter int unsigned CLK_DIV  = 4,  // clk cycles per sclk half-period
  parameter int unsigned CS_SETUP = 2,  // ncs low before the first sclk low phase
  parameter int unsigned CS_HOLD  = 2,  // ncs low after the last sclk fall
  parameter int unsigned GAP      = 4   // ncs high before the next request is taken
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       ncs_o,
  output logic       copi_o
);

  // The peripheral resynchronises sclk through two flops plus an edge
  // detector, so each sclk level must last at least three clk cycles.
  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("spi_controller_tx: CLK_DIV must be >= 3");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_controller_tx: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_controller_tx: CS_HOLD must be >= 1");
  end
  if (GAP < 2) begin : g_bad_gap
    $error("spi_controller_tx: GAP must be >= 2");
  end

  localparam int unsigned HP_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CS_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned CNT_MAX = (CS_MAX > GAP) ? CS_MAX : GAP;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [HP_W-1:0]  HP_LAST    = HP_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       frame_q, frame_d;
  logic [3:0]        bit_q,   bit_d;    // index of the bit currently on copi
  logic [HP_W-1:0]   hp_q,    hp_d;     // cycles spent in this sclk half-period
  logic [CNT_W-1:0]  cnt_q,   cnt_d;    // shared SETUP/HOLD/GAP dwell counter
  logic              sclk_q,  sclk_d;
  logic              ncs_q,   ncs_d;
  logic              copi_q,  copi_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sclk_o      = sclk_q;
  assign ncs_o       = ncs_q;
  assign copi_o      = copi_q;

  // State and output registers; reset drops every output to its idle level.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      bit_q   <= '0;
      hp_q    <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      bit_q   <= bit_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    bit_d   = bit_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          // Latch the frame now; the request inputs are ignored from here on.
          frame_d = {1'b1, req_addr_i, req_data_i};
          ncs_d   = 1'b0;
          sclk_d  = 1'b0;
          copi_d  = frame_d[15];
          busy_d  = 1'b1;
          bit_d   = 4'd15;
          hp_d    = '0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          hp_d    = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SHIFT: begin
        if (hp_q == HP_LAST) begin
          hp_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: the only place copi may move, so the peripheral
            // always sees a settled bit across the following rise.
            sclk_d = 1'b0;
            if (bit_q == 4'd0) begin
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              bit_d  = bit_q - 4'd1;
              copi_d = frame_q[bit_q - 4'd1];
            end
          end
        end else begin
          hp_d = hp_q + HP_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        // done lives only in the first cycle ncs is back high.
        done_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller_tx.sv
// Bench for spi_controller_tx. Instance 0 uses the default timing, instance 1
// uses CLK_DIV=3. A bus monitor captures each frame from ncs/sclk/copi and
// checks timing rules; the main sequence compares captured frames with
// expectations built from the request fields alone.
module tb_spi_controller_tx;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int GAP      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0]      vld  = '0;
  logic [1:0][6:0] addr = '0;
  logic [1:0][7:0] dat  = '0;
  logic [1:0] rdy_w, busy_w, done_w, sclk_w, ncs_w, copi_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_controller_tx #(.CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(vld[0]), .req_ready_o(rdy_w[0]),
    .req_addr_i(addr[0]), .req_data_i(dat[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .sclk_o(sclk_w[0]), .ncs_o(ncs_w[0]), .copi_o(copi_w[0]));

  spi_controller_tx #(.CLK_DIV(3), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .GAP(GAP)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(vld[1]), .req_ready_o(rdy_w[1]),
    .req_addr_i(addr[1]), .req_data_i(dat[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .sclk_o(sclk_w[1]), .ncs_o(ncs_w[1]), .copi_o(copi_w[1]));

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_frame(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic int ref_low(input int div);
    return CS_SETUP + 32 * div + CS_HOLD;
  endfunction
  function automatic int div_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  // ---------------- bus monitor ----------------
  typedef struct {
    int          dut;
    logic [15:0] frame;
    int          rises;
    int          lowc;
    int          tbad;
    int          cbad;
    int          start;
    int          stop;
  } rec_t;
  rec_t recq[$];

  bit [1:0]    p_sclk = '0, p_ncs = '1, p_copi = '0;
  logic [15:0] sh [2];
  int rises [2], lowc [2], since_rise [2], hi_run [2], tbad [2], cbad [2], start_c [2];
  int done_err [2], busy_err [2];
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        if (done_w[k] || !ncs_w[k]) done_err[k]++;
        rises[k] = 0;
        lowc[k]  = 0;
      end else begin
        if (rdy_w[k] == busy_w[k]) busy_err[k]++;
        if (!ncs_w[k] && !busy_w[k]) busy_err[k]++;
        if (!ncs_w[k]) begin
          if (p_ncs[k]) begin
            rises[k] = 0; lowc[k] = 0; tbad[k] = 0; cbad[k] = 0;
            since_rise[k] = 0; hi_run[k] = 0; start_c[k] = cyc; sh[k] = '0;
          end
          lowc[k]++;
          since_rise[k]++;
          if (sclk_w[k]) hi_run[k]++;
          if (sclk_w[k] && !p_sclk[k]) begin
            sh[k] = {sh[k][14:0], copi_w[k]};
            if (rises[k] == 0) begin
              if (lowc[k] != CS_SETUP + div_of(k) + 1) tbad[k]++;
            end else if (since_rise[k] != 2 * div_of(k)) begin
              tbad[k]++;
            end
            rises[k]++;
            since_rise[k] = 0;
          end
          if (!sclk_w[k] && p_sclk[k]) begin
            if (hi_run[k] != div_of(k)) tbad[k]++;
            hi_run[k] = 0;
          end
          // copi may only move together with a sclk fall while ncs stays low
          if (!p_ncs[k] && (copi_w[k] != p_copi[k]) && !(!sclk_w[k] && p_sclk[k])) cbad[k]++;
          if (done_w[k]) done_err[k]++;
        end else if (!p_ncs[k]) begin
          if (!done_w[k]) done_err[k]++;
          if (sclk_w[k] || copi_w[k]) tbad[k]++;
          recq.push_back('{k, sh[k], rises[k], lowc[k], tbad[k], cbad[k], start_c[k], cyc});
        end else if (done_w[k]) begin
          done_err[k]++;
        end
      end
      p_sclk[k] = sclk_w[k];
      p_ncs[k]  = ncs_w[k];
      p_copi[k] = copi_w[k];
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present a request, wait for acceptance, then drop valid and scramble the inputs.
  task automatic do_write(input int k, input logic [6:0] a, input logic [7:0] d);
    int t;
    @(negedge clk);
    vld[k] = 1'b1; addr[k] = a; dat[k] = d;
    t = 0;
    while (!rdy_w[k] && t < 400) begin @(negedge clk); t++; end
    chk($sformatf("accept%0d", k), rdy_w[k], 1);
    @(posedge clk); #1;
    vld[k]  = 1'b0;
    addr[k] = 7'($urandom);
    dat[k]  = 8'($urandom);
  endtask

  task automatic wait_rec(input int k, output rec_t r, output bit ok);
    int t;
    t = 0;
    while (recq.size() == 0 && t < 2000) begin @(negedge clk); t++; end
    chk("frame_arrived", recq.size() > 0, 1);
    ok = (recq.size() > 0);
    if (ok) begin
      r = recq.pop_front();
      chk("frame_dut", r.dut, k);
    end
  endtask

  task automatic check_frame(input string tag, input rec_t r, input logic [15:0] e, input int div);
    chk({tag, "_frame"}, r.frame, e);
    chk({tag, "_rises"}, r.rises, 16);
    chk({tag, "_ncs_low"}, r.lowc, ref_low(div));
    chk({tag, "_sclk_timing"}, r.tbad, 0);
    chk({tag, "_copi_stable"}, r.cbad, 0);
  endtask

  typedef struct {
    logic [6:0]  a;
    logic [7:0]  d;
    logic [15:0] e;
  } vec_t;

  // ---------------- main sequence ----------------
  initial begin
    vec_t        vt [6];
    rec_t        r, r2;
    bit          ok, ok2;
    logic [7:0]  pregs [128];
    logic [7:0]  wdat [5];
    logic [6:0]  ra;
    logic [7:0]  rd;
    int          t;

    vt[0] = '{7'h04, 8'h80, 16'h8480};
    vt[1] = '{7'h00, 8'hFF, 16'h80FF};
    vt[2] = '{7'h01, 8'h0F, 16'h810F};
    vt[3] = '{7'h7F, 8'h00, 16'hFF00};
    vt[4] = '{7'h55, 8'hAA, 16'hD5AA};
    vt[5] = '{7'h2A, 8'h55, 16'hAA55};
    for (int i = 0; i < 128; i++) pregs[i] = '0;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs_w[0], 1);
    chk("rst_sclk", sclk_w[0], 0);
    chk("rst_copi", copi_w[0], 0);
    chk("rst_ready", rdy_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_done", done_w[0], 0);
    chk("rst_ncs1", ncs_w[1], 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy_w[0], 1);

    // Table-driven single writes
    for (int i = 0; i < 6; i++) begin
      do_write(0, vt[i].a, vt[i].d);
      wait_rec(0, r, ok);
      if (ok) check_frame($sformatf("vec%0d", i), r, vt[i].e, 4);
    end

    // Back-to-back: valid held across two requests
    @(negedge clk);
    vld[0] = 1'b1; addr[0] = 7'h00; dat[0] = 8'hFF;
    t = 0;
    while (!rdy_w[0] && t < 400) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    addr[0] = 7'h01; dat[0] = 8'h0F;
    @(negedge clk);
    chk("b2b_ready_low", rdy_w[0], 0);
    t = 0;
    while (!rdy_w[0] && t < 400) begin @(negedge clk); t++; end
    chk("b2b_accept2", rdy_w[0], 1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_rec(0, r, ok);
    wait_rec(0, r2, ok2);
    if (ok && ok2) begin
      check_frame("b2b_a", r, 16'h80FF, 4);
      check_frame("b2b_b", r2, 16'h810F, 4);
      chk("b2b_period", r2.start - r.start, ref_low(4) + GAP + 1);
      chk("b2b_gap_ge4", (r2.start - r.stop) >= 4, 1);
    end

    // Loopback into a register-file model of the peripheral
    for (int i = 0; i < 5; i++) begin
      wdat[i] = 8'($urandom_range(0, 255));
      do_write(0, 7'(i), wdat[i]);
      wait_rec(0, r, ok);
      if (ok && r.frame[15]) pregs[r.frame[14:8]] = r.frame[7:0];
    end
    for (int i = 0; i < 5; i++) chk($sformatf("periph_reg%0d", i), pregs[i], wdat[i]);

    // Randomised writes on the default instance
    for (int i = 0; i < 8; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      do_write(0, ra, rd);
      wait_rec(0, r, ok);
      if (ok) check_frame($sformatf("rnd%0d", i), r, ref_frame(ra, rd), 4);
    end

    // Reset during bit 7 (high phase of the ninth bit)
    do_write(0, 7'h33, 8'hC3);
    t = 0;
    while (!(rises[0] == 9 && sclk_w[0]) && t < 400) begin @(negedge clk); t++; end
    chk("midrst_reached_bit7", rises[0], 9);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ncs", ncs_w[0], 1);
    chk("midrst_sclk", sclk_w[0], 0);
    chk("midrst_copi", copi_w[0], 0);
    chk("midrst_busy", busy_w[0], 0);
    chk("midrst_done", done_w[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_frame", recq.size(), 0);
    chk("midrst_ready", rdy_w[0], 1);
    do_write(0, 7'h12, 8'h34);
    wait_rec(0, r, ok);
    if (ok) check_frame("post_midrst", r, 16'h9234, 4);

    // CLK_DIV=3 instance: period/duty and copi stability via monitor
    for (int i = 0; i < 6; i++) begin
      ra = 7'($urandom_range(0, 127));
      rd = 8'($urandom_range(0, 255));
      do_write(1, ra, rd);
      wait_rec(1, r, ok);
      if (ok) check_frame($sformatf("div3_%0d", i), r, ref_frame(ra, rd), 3);
    end

    repeat (10) @(negedge clk);
    chk("done_pulse_rules0", done_err[0], 0);
    chk("done_pulse_rules1", done_err[1], 0);
    chk("busy_ready_rules0", busy_err[0], 0);
    chk("busy_ready_rules1", busy_err[1], 0);
    chk("no_stray_frames", recq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
